// File: rtl/ether_cmd_sequencer_if.sv
// ether_cmd_sequencer_if
// Groups the command sequencer's control inputs and serial/status outputs.
//   trigger_btn_n : raw active-low start button (asynchronous to clk_in)
//   loop_en       : restart the sequence after the last gap
//   abort         : stop transmission and return to idle
//   frame_data    : NUM_FRAMES frames, frame k at [(k+1)*FRAME_LEN-1 : k*FRAME_LEN]
//   bit_clk_out   : serial bit clock, rising mid-bit
//   pulse_out     : serial data, idle high
//   busy          : sequencer not idle
//   frame_idx     : frame being sent or gapped
//   done          : one-cycle pulse when a non-looping sequence finishes
// Modports: master drives the controls, slave is the sequencer.
interface ether_cmd_sequencer_if #(
  parameter int FRAME_LEN  = 58,
  parameter int NUM_FRAMES = 3,
  parameter int IDX_W      = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
);
  logic                            trigger_btn_n;
  logic                            loop_en;
  logic                            abort;
  logic [NUM_FRAMES*FRAME_LEN-1:0] frame_data;
  logic                            bit_clk_out;
  logic                            pulse_out;
  logic                            busy;
  logic [IDX_W-1:0]                frame_idx;
  logic                            done;

  modport master (
    output trigger_btn_n, loop_en, abort, frame_data,
    input  bit_clk_out, pulse_out, busy, frame_idx, done
  );

  modport slave (
    input  trigger_btn_n, loop_en, abort, frame_data,
    output bit_clk_out, pulse_out, busy, frame_idx, done
  );
endinterface

// File: rtl/ether_cmd_sequencer_btn_debounce.sv
// btn_debounce
// Synchronises a raw active-low button, accepts a new level only after it
// has been stable for DEBOUNCE_CYCLES clk_in cycles, and emits a one-cycle
// pulse when the accepted level goes from released (1) to pressed (0).
//   clk_in, reset_in : clock, asynchronous active-high reset
//   btn_n_in         : raw button, asynchronous to clk_in
//   fall_pulse       : one-cycle press event
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 200000
) (
  input  logic clk_in,
  input  logic reset_in,
  input  logic btn_n_in,
  output logic fall_pulse
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_q1, sync_q2;
  logic             level_q;
  logic [CNT_W-1:0] cnt_q;

  // The counter runs only while the synchronised input disagrees with the
  // accepted level; any return to agreement restarts the stability window.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      sync_q1    <= 1'b1;
      sync_q2    <= 1'b1;
      level_q    <= 1'b1;
      cnt_q      <= '0;
      fall_pulse <= 1'b0;
    end else begin
      sync_q1    <= btn_n_in;
      sync_q2    <= sync_q1;
      fall_pulse <= 1'b0;
      if (sync_q2 != level_q) begin
        if (cnt_q == CNT_LAST) begin
          level_q    <= sync_q2;
          cnt_q      <= '0;
          fall_pulse <= ~sync_q2;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end
endmodule

// File: rtl/ether_cmd_sequencer.sv
// ether_cmd_sequencer
// On a debounced button press, shifts NUM_FRAMES frames of FRAME_LEN bits
// out MSB-first on pulse_out with a mid-bit rising bit_clk_out, each frame
// followed by GAP_BITS idle bit periods. Optionally loops; abort stops it.
//   clk_in, reset_in : sole clock, asynchronous active-high reset
//   bus (slave)      : controls, frame data, serial outputs and status
module ether_cmd_sequencer #(
  parameter int FRAME_LEN       = 58,
  parameter int NUM_FRAMES      = 3,
  parameter int CLK_DIV         = 320,
  parameter int GAP_BITS        = 10000,
  parameter int DEBOUNCE_CYCLES = 200000
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  ether_cmd_sequencer_if.slave  bus
);
  localparam int IDX_W   = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam int DIV_W   = $clog2(CLK_DIV) + 1;
  localparam int BIT_W   = $clog2(FRAME_LEN) + 1;
  localparam int GAP_W   = $clog2(GAP_BITS) + 1;
  localparam int SH_BITS = NUM_FRAMES * FRAME_LEN;
  localparam int SH_W    = (SH_BITS > 1) ? $clog2(SH_BITS) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_LEN - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_FRAMES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [SH_BITS-1:0] shadow_q, shadow_d;
  logic               done_q, done_d;
  logic               start_evt;
  logic               bit_tick;
  logic [SH_W-1:0]    sel;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clk_in     (clk_in),
    .reset_in   (reset_in),
    .btn_n_in   (bus.trigger_btn_n),
    .fall_pulse (start_evt)
  );

  assign bit_tick = (div_q == DIV_LAST);

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q  <= IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      gap_q    <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      gap_q    <= gap_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    gap_d    = gap_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Presses while SEND/GAP are simply not looked at, so nothing queues.
        if (start_evt) begin
          state_d  = SEND;
          idx_d    = '0;
          bit_d    = '0;
          div_d    = '0;
          shadow_d = bus.frame_data;
        end
      end
      SEND: begin
        if (bus.abort) begin
          state_d = IDLE;
          div_d   = '0;
          bit_d   = '0;
          gap_d   = '0;
          idx_d   = '0;
        end else begin
          div_d = bit_tick ? '0 : div_q + 1'b1;
          if (bit_tick) begin
            if (bit_q == BIT_LAST) begin
              state_d = GAP;
              bit_d   = '0;
              gap_d   = '0;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end
        end
      end
      GAP: begin
        // Abort is checked first so it beats a coincident gap end.
        if (bus.abort) begin
          state_d = IDLE;
          div_d   = '0;
          bit_d   = '0;
          gap_d   = '0;
          idx_d   = '0;
        end else begin
          div_d = bit_tick ? '0 : div_q + 1'b1;
          if (bit_tick) begin
            if (gap_q == GAP_LAST) begin
              gap_d = '0;
              bit_d = '0;
              if (idx_q != IDX_LAST) begin
                state_d = SEND;
                idx_d   = idx_q + 1'b1;
              end else if (bus.loop_en) begin
                state_d  = SEND;
                idx_d    = '0;
                shadow_d = bus.frame_data;
              end else begin
                state_d = IDLE;
                idx_d   = '0;
                done_d  = 1'b1;
              end
            end else begin
              gap_d = gap_q + 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // MSB of frame idx_q sits at idx_q*FRAME_LEN + FRAME_LEN-1.
  assign sel = SH_W'(int'(idx_q) * FRAME_LEN + (FRAME_LEN - 1) - int'(bit_q));

  // Outputs decode registered state only, so reset reaches them immediately.
  assign bus.pulse_out   = (state_q == SEND) ? shadow_q[sel] : 1'b1;
  assign bus.bit_clk_out = (state_q == SEND) ? (div_q >= DIV_HALF) : 1'b1;
  assign bus.busy        = (state_q != IDLE);
  assign bus.frame_idx   = idx_q;
  assign bus.done        = done_q;
endmodule

// File: tb/tb_ether_cmd_sequencer.sv
module tb_ether_cmd_sequencer;
  localparam int FL    = 4;
  localparam int NF    = 2;
  localparam int CD    = 4;
  localparam int GB    = 2;
  localparam int DB    = 3;
  localparam int IDX_W = 1;
  localparam int PASS  = NF * (FL + GB) * CD;

  typedef struct packed {
    logic             pulse;
    logic             bclk;
    logic [IDX_W-1:0] idx;
    logic             busy;
    logic             done;
  } exp_t;

  logic clk_in   = 1'b0;
  logic reset_in = 1'b1;
  always #5 clk_in = ~clk_in;

  ether_cmd_sequencer_if #(.FRAME_LEN(FL), .NUM_FRAMES(NF)) bus ();

  ether_cmd_sequencer #(
    .FRAME_LEN(FL), .NUM_FRAMES(NF), .CLK_DIV(CD),
    .GAP_BITS(GB), .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .bus      (bus)
  );

  exp_t q[$];
  exp_t mon_e, mon_got;
  int   vectors    = 0;
  int   miscompares = 0;
  int   cur;

  function automatic exp_t mk(input logic p, input logic c, input int k,
                              input logic b, input logic d);
    exp_t e;
    e.pulse = p; e.bclk = c; e.idx = k[IDX_W-1:0]; e.busy = b; e.done = d;
    return e;
  endfunction

  // Reference: the cycle-by-cycle waveform from the first SEND cycle on.
  // last_item < 0 means the sequence runs to completion and ends with done.
  task automatic push_seq(input logic [7:0] d_first, input logic [7:0] d_rest,
                          input int passes, input int last_item);
    int n = 0;
    logic [7:0]    data;
    logic [FL-1:0] fr;
    for (int p = 0; p < passes; p++) begin
      data = (p == 0) ? d_first : d_rest;
      for (int k = 0; k < NF; k++) begin
        fr = data[k*FL +: FL];
        for (int b = 0; b < FL; b++)
          for (int d = 0; d < CD; d++) begin
            if (last_item < 0 || n <= last_item)
              q.push_back(mk(fr[FL-1-b], (d >= CD/2), k, 1'b1, 1'b0));
            n++;
          end
        for (int g = 0; g < GB*CD; g++) begin
          if (last_item < 0 || n <= last_item)
            q.push_back(mk(1'b1, 1'b1, k, 1'b1, 1'b0));
          n++;
        end
      end
    end
    if (last_item < 0) q.push_back(mk(1'b1, 1'b1, 0, 1'b0, 1'b1));
  endtask

  // Monitor: idle cycles must show idle outputs; active cycles pop the model.
  always @(negedge clk_in) begin
    if (reset_in || (!bus.busy && !bus.done)) begin
      vectors++;
      if (bus.pulse_out !== 1'b1 || bus.bit_clk_out !== 1'b1 ||
          bus.frame_idx !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_outputs t=%0t got pulse=%b bclk=%b idx=%0d busy=%b done=%b want 1 1 0 0 0",
                 $time, bus.pulse_out, bus.bit_clk_out, bus.frame_idx, bus.busy, bus.done);
      end
    end else if (q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL unexpected_activity t=%0t got busy=%b done=%b want idle",
               $time, bus.busy, bus.done);
    end else begin
      mon_e   = q.pop_front();
      mon_got = {bus.pulse_out, bus.bit_clk_out, bus.frame_idx, bus.busy, bus.done};
      vectors++;
      if (mon_got !== mon_e) begin
        miscompares++;
        $display("FAIL serial_trace t=%0t got pulse/bclk/idx/busy/done=%b want %b",
                 $time, mon_got, mon_e);
      end
    end
  end

  task automatic wait_busy();
    cur = 0;
    for (int i = 0; i < 40 && !bus.busy; i++) @(negedge clk_in);
    vectors++;
    if (!bus.busy) begin
      miscompares++;
      $display("FAIL start_timeout got busy=%b want 1", bus.busy);
    end
  endtask

  task automatic go_to(input int t);
    while (cur < t) begin
      @(negedge clk_in);
      cur++;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 600 && q.size() != 0; i++) @(negedge clk_in);
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout got %0d items pending want 0", q.size());
      q.delete();
    end
    repeat (12) @(negedge clk_in);
  endtask

  task automatic run_single(input logic [7:0] d);
    bus.frame_data = d;
    push_seq(d, d, 1, -1);
    bus.trigger_btn_n = 1'b0;
    wait_busy();
    go_to(3);
    bus.trigger_btn_n = 1'b1;
    drain();
  endtask

  task automatic run_abort(input logic [7:0] d, input int j);
    bus.frame_data = d;
    push_seq(d, d, 1, j);
    bus.trigger_btn_n = 1'b0;
    wait_busy();
    go_to(3);
    bus.trigger_btn_n = 1'b1;
    go_to(j);
    bus.abort = 1'b1;
    @(negedge clk_in);
    bus.abort = 1'b0;
    drain();
  endtask

  initial begin
    logic [7:0] d1, d2;
    int j;
    bus.trigger_btn_n = 1'b1;
    bus.loop_en       = 1'b0;
    bus.abort         = 1'b0;
    bus.frame_data    = '0;
    repeat (3) @(negedge clk_in);
    reset_in = 1'b0;
    repeat (10) @(negedge clk_in);

    // Directed A5 with a second press during SEND that must be ignored.
    bus.frame_data = 8'hA5;
    push_seq(8'hA5, 8'hA5, 1, -1);
    bus.trigger_btn_n = 1'b0;
    wait_busy();
    go_to(3);  bus.trigger_btn_n = 1'b1;
    go_to(12); bus.trigger_btn_n = 1'b0;
    go_to(22); bus.trigger_btn_n = 1'b1;
    drain();

    // Two-cycle glitch: no start.
    bus.trigger_btn_n = 1'b0;
    repeat (2) @(negedge clk_in);
    bus.trigger_btn_n = 1'b1;
    repeat (30) @(negedge clk_in);
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL glitch_start got busy=%b want 0", bus.busy);
    end

    // Abort while idle has no effect (monitor checks idle outputs).
    bus.abort = 1'b1;
    repeat (5) @(negedge clk_in);
    bus.abort = 1'b0;

    for (int r = 0; r < 4; r++) run_single(8'($urandom));

    // Loop: frame_data changed mid-pass must only show up on the reload;
    // loop_en dropped during frame 1 of pass 2 ends after that pass.
    d1 = 8'($urandom);
    d2 = 8'($urandom);
    bus.frame_data = d1;
    bus.loop_en    = 1'b1;
    push_seq(d1, d2, 2, -1);
    bus.trigger_btn_n = 1'b0;
    wait_busy();
    go_to(3);         bus.trigger_btn_n = 1'b1;
    go_to(5);         bus.frame_data = d2;
    go_to(PASS + 30); bus.loop_en = 1'b0;
    drain();

    run_abort(8'($urandom), 28);          // 2nd bit of frame 1
    run_abort(8'($urandom), PASS - 1);    // coincident with final gap end
    for (int r = 0; r < 2; r++) run_abort(8'($urandom), $urandom_range(4, PASS - 1));

    // Asynchronous reset in the gap after frame 0.
    d1 = 8'($urandom);
    j  = $urandom_range(FL*CD, FL*CD + GB*CD - 1);
    bus.frame_data = d1;
    push_seq(d1, d1, 1, j);
    bus.trigger_btn_n = 1'b0;
    wait_busy();
    go_to(3); bus.trigger_btn_n = 1'b1;
    go_to(j);
    #1 reset_in = 1'b1;
    #1;
    vectors++;
    if (bus.pulse_out !== 1'b1 || bus.bit_clk_out !== 1'b1 || bus.busy !== 1'b0 ||
        bus.done !== 1'b0 || bus.frame_idx !== '0) begin
      miscompares++;
      $display("FAIL async_reset got pulse=%b bclk=%b busy=%b done=%b idx=%0d want 1 1 0 0 0",
               bus.pulse_out, bus.bit_clk_out, bus.busy, bus.done, bus.frame_idx);
    end
    repeat (2) @(negedge clk_in);
    reset_in = 1'b0;
    repeat (30) @(negedge clk_in);
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL reset_trace got %0d items pending want 0", q.size());
      q.delete();
    end
    run_single(8'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
